// File: rtl/lsu_lane_ctrl.sv
// Load/store lane controller: aligns MIPS load/store requests onto a DATA_W memory bus,
// runs a timed-out memory handshake and returns extended load data over valid/ready.
module lsu_lane_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_err
);
  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  state_t state_reg, state_next;

  logic                accept;
  logic [OFF_W-1:0]    req_off;
  logic [3:0]          req_nb;
  logic                size_bad;
  logic                misaligned;
  logic [NBYTES-1:0]   be_base;
  logic [NBYTES-1:0]   be_lane;
  logic [DATA_W-1:0]   wdata_mask;
  logic [DATA_W-1:0]   wdata_lane;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   rd_ext;
  logic                sign_bit;
  logic                timeout_hit;

  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [NBYTES-1:0]   mem_be_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic [OFF_W-1:0]    off_reg;
  logic [1:0]          size_reg;
  logic [3:0]          nb_reg;
  logic                unsigned_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic [1:0]          err_reg;

  assign accept     = req_valid && (state_reg == IDLE);
  assign req_off    = req_addr[OFF_W-1:0];
  assign req_nb     = 4'd1 << req_size;
  assign size_bad   = (req_size == 2'd3) && (DATA_W == 32);
  assign misaligned = |({{(4-OFF_W){1'b0}}, req_off} & (req_nb - 4'd1));
  assign nb_reg     = 4'd1 << size_reg;

  // Per-byte masks: low NB bytes selected for the store data and load result.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign be_base[gi]          = (4'(gi) < req_nb);
    assign wdata_mask[8*gi +: 8] = (4'(gi) < req_nb) ? 8'hFF : 8'h00;
    assign rd_ext[8*gi +: 8]     = (4'(gi) < nb_reg) ? rd_shift[8*gi +: 8] : {8{sign_bit}};
  end

  assign be_lane    = be_base << req_off;
  assign wdata_lane = (req_wdata & wdata_mask) << {req_off, 3'b000};
  assign rd_shift   = mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    sign_bit = 1'b0;
    if (!unsigned_reg) begin
      case (size_reg)
        2'd0:    sign_bit = rd_shift[7];
        2'd1:    sign_bit = rd_shift[15];
        2'd2:    sign_bit = rd_shift[31];
        default: sign_bit = rd_shift[DATA_W-1];
      endcase
    end
  end

  // cnt_reg holds the number of MEM cycles already completed.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= '0;
      mem_wdata_reg <= '0;
      off_reg       <= '0;
      size_reg      <= '0;
      unsigned_reg  <= 1'b0;
      cnt_reg       <= '0;
      rdata_reg     <= '0;
      err_reg       <= 2'b00;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (accept) begin
          cnt_reg      <= '0;
          rdata_reg    <= '0;
          off_reg      <= req_off;
          size_reg     <= req_size;
          unsigned_reg <= req_unsigned;
          if (size_bad)        err_reg <= 2'b11;
          else if (misaligned) err_reg <= 2'b01;
          else begin
            err_reg       <= 2'b00;
            mem_we_reg    <= req_we;
            mem_addr_reg  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be_reg    <= be_lane;
            mem_wdata_reg <= wdata_lane;
          end
        end
        MEM: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (mem_ack) begin
            if (!mem_we_reg) rdata_reg <= rd_ext;
          end else if (timeout_hit) begin
            err_reg <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (size_bad || misaligned) ? RESP : MEM;
      MEM:     if (mem_ack || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE);
    mem_req   = (state_reg == MEM);
    rsp_valid = (state_reg == RESP);
    mem_we    = mem_we_reg;
    mem_addr  = mem_addr_reg;
    mem_be    = mem_be_reg;
    mem_wdata = mem_wdata_reg;
    rsp_rdata = rdata_reg;
    rsp_err   = err_reg;
  end
endmodule

// File: tb/tb_lsu_lane_ctrl.sv
// Randomised and directed bench for lsu_lane_ctrl (DATA_W=32, TIMEOUT=4) against an
// arithmetic reference model of lane alignment, extension, errors and timing.
module tb_lsu_lane_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  int tests = 0;
  int fails = 0;

  lsu_lane_ctrl #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Reference model: plain byte arithmetic on the request fields.
  function automatic logic [1:0] model_err(logic [1:0] size, logic [31:0] addr, int ack_delay);
    int nb = 1 << size;
    if (size == 2'd3) return 2'b11;
    if ((addr % nb) != 0) return 2'b01;
    if (ack_delay >= TO) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] model_load(logic [1:0] size, logic uns, logic [31:0] addr,
                                             logic [31:0] rdata);
    int nb = 1 << size;
    int off = addr % 4;
    longint unsigned v, m;
    m = (64'd1 << (8 * nb)) - 1;
    v = (longint'(rdata) >> (8 * off)) & m;
    if (!uns && v >= (m + 1) / 2) v = v | ~m;
    return v[31:0];
  endfunction

  // Drives one request and follows it through to the response handshake.
  task automatic run_txn(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_delay, input logic [31:0] rdata, input int ready_delay);
    logic [1:0]  e_err;
    logic [31:0] e_rdata, e_wdata, held_rdata;
    logic [3:0]  e_be;
    int nb, off, lat, mcyc, e_lat, e_mcyc;
    logic [1:0]  held_err;
    nb = 1 << size;
    off = addr % 4;
    e_err = model_err(size, addr, ack_delay);
    e_be = 4'(((1 << nb) - 1) << off);
    e_wdata = 32'((longint'(wdata) & ((64'd1 << (8 * nb)) - 1)) << (8 * off));
    e_rdata = (e_err == 2'b00 && !we) ? model_load(size, uns, addr, rdata) : 32'd0;
    e_lat  = (e_err == 2'b11 || e_err == 2'b01) ? 1 : (e_err == 2'b10 ? TO + 1 : ack_delay + 2);
    e_mcyc = (e_err == 2'b11 || e_err == 2'b01) ? 0 : (e_err == 2'b10 ? TO : ack_delay + 1);

    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL %s req_ready_idle got=%b exp=1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    lat = 1; mcyc = 0;
    if (mem_req) begin
      tests++;
      if (mem_addr !== {addr[31:2], 2'b00} || mem_be !== e_be || mem_we !== we ||
          (we && mem_wdata !== e_wdata)) begin
        fails++;
        $display("FAIL %s mem_fields got addr=%h be=%b we=%b wd=%h exp addr=%h be=%b we=%b wd=%h",
                 name, mem_addr, mem_be, mem_we, mem_wdata, {addr[31:2], 2'b00}, e_be, we, e_wdata);
      end
    end
    while (!rsp_valid && lat < 20) begin
      if (mem_req) begin
        if (mcyc == ack_delay) begin mem_ack = 1'b1; mem_rdata = rdata; end
        mcyc++;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = $urandom;
      lat++;
    end
    tests++;
    if (lat !== e_lat || mcyc !== e_mcyc) begin
      fails++; $display("FAIL %s latency got lat=%0d memcyc=%0d exp lat=%0d memcyc=%0d",
                        name, lat, mcyc, e_lat, e_mcyc);
    end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== e_err || rsp_rdata !== e_rdata) begin
      fails++; $display("FAIL %s response got v=%b err=%b rd=%h exp v=1 err=%b rd=%h",
                        name, rsp_valid, rsp_err, rsp_rdata, e_err, e_rdata);
    end
    held_rdata = rsp_rdata; held_err = rsp_err;
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== held_rdata ||
          rsp_err !== held_err || mem_req !== 1'b0) begin
        fails++; $display("FAIL %s hold got v=%b rdy=%b rd=%h err=%b mreq=%b exp v=1 rdy=0 rd=%h err=%b mreq=0",
                          name, rsp_valid, req_ready, rsp_rdata, rsp_err, mem_req, held_rdata, held_err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL %s release got v=%b rdy=%b exp v=0 rdy=1", name, rsp_valid, req_ready);
    end
    $display("[TB] txn %s we=%0d size=%0d uns=%0d addr=%h err=%b rdata=%h lat=%0d",
             name, we, size, uns, addr, rsp_err, e_rdata, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
        mem_be !== 4'd0 || mem_wdata !== 32'd0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 ||
        rsp_err !== 2'b00) begin
      fails++; $display("FAIL reset_state got rdy=%b mreq=%b we=%b a=%h be=%b wd=%h v=%b rd=%h err=%b",
                        req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, rsp_valid, rsp_rdata, rsp_err);
    end
    $display("[TB] txn reset");
  endtask

  task automatic test_directed();
    run_txn("load_byte_signed", 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 0, 32'h80000000, 0);
    run_txn("store_half",       1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234ABCD, 0, 32'hDEADBEEF, 0);
    run_txn("load_word_misal",  1'b0, 2'd2, 1'b0, 32'h3002, 32'h0, 0, 32'h0, 0);
    run_txn("size3_illegal",    1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 0, 32'h0, 0);
    run_txn("size3_misaddr",    1'b1, 2'd3, 1'b1, 32'h3001, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    run_txn("timeout_load",  1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 10, 32'h11223344, 0);
    run_txn("ack_at_limit",  1'b0, 2'd2, 1'b0, 32'h5004, 32'h0, TO - 1, 32'h11223344, 0);
    run_txn("timeout_store", 1'b1, 2'd0, 1'b0, 32'h5001, 32'hAB, 10, 32'h0, 1);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", 1'b0, 2'd1, 1'b1, 32'h4002, 32'h0, 0, 32'hBEEF1234, 3);
  endtask

  task automatic test_reset_mid();
    int n;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h6000;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 5) begin @(negedge clk); n++; end
    tests++;
    if (mem_req !== 1'b1) begin
      fails++; $display("FAIL rst_mid_enter mem_req got=%b exp=1", mem_req);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || mem_be !== 4'd0 || mem_addr !== 32'd0) begin
      fails++; $display("FAIL rst_mid_clear got mreq=%b v=%b be=%b a=%h exp all 0",
                        mem_req, rsp_valid, mem_be, mem_addr);
    end
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin
        fails++; $display("FAIL rst_mid_late_ack got v=%b mreq=%b rdy=%b exp v=0 mreq=0 rdy=1",
                          rsp_valid, mem_req, req_ready);
      end
      @(negedge clk);
    end
    $display("[TB] txn reset_mid_mem");
  endtask

  task automatic test_random();
    logic [1:0]  size;
    logic [31:0] addr;
    int nb;
    for (int t = 0; t < 40; t++) begin
      size = 2'($urandom_range(0, 3));
      nb = 1 << size;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(nb - 1);
      run_txn("random", 1'($urandom), size, 1'($urandom), addr, $urandom,
              $urandom_range(0, 5), $urandom, $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_a", 1'b0, 2'd0, 1'b1, 32'h7001, 32'h0, 0, 32'h0000C300, 0);
    run_txn("b2b_b", 1'b0, 2'd1, 1'b0, 32'h7000, 32'h0, 1, 32'h0000C300, 0);
    run_txn("b2b_c", 1'b1, 2'd2, 1'b0, 32'h7004, 32'h89ABCDEF, 2, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
